// File: rtl/toast_imem_responder_if.sv
// ---------------------------------------------------------------------------
// toast_imem_responder_if
//   Bundles the fetch bus and the byte-serial program loader of the
//   instruction-memory responder.
//   Fetch side : IMEM_addr_i (byte address) -> IMEM_data_o / addr_err_o,
//                one cycle later.
//   Loader side: load_start_i pulse, then load_byte_i / load_valid_i /
//                load_last_i against load_ready_o. load_done_o pulses when the
//                image is in memory, load_ovf_o flags bytes beyond capacity.
//   core_hold_o keeps the core stalled while a load is in progress.
//   slave  : the responder
//   master : fetch stage / loader host (or a testbench)
// ---------------------------------------------------------------------------
interface toast_imem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] IMEM_addr_i;
  logic [DATA_WIDTH-1:0] IMEM_data_o;
  logic                  addr_err_o;
  logic                  load_start_i;
  logic [7:0]            load_byte_i;
  logic                  load_valid_i;
  logic                  load_last_i;
  logic                  load_ready_o;
  logic                  load_done_o;
  logic                  load_ovf_o;
  logic                  core_hold_o;

  modport slave (
    input  IMEM_addr_i, load_start_i, load_byte_i, load_valid_i, load_last_i,
    output IMEM_data_o, addr_err_o, load_ready_o, load_done_o, load_ovf_o,
           core_hold_o
  );

  modport master (
    output IMEM_addr_i, load_start_i, load_byte_i, load_valid_i, load_last_i,
    input  IMEM_data_o, addr_err_o, load_ready_o, load_done_o, load_ovf_o,
           core_hold_o
  );
endinterface

// File: rtl/toast_imem_responder.sv
// ---------------------------------------------------------------------------
// toast_imem_responder
//   Instruction memory behind the IF stage. Every cycle the byte address on
//   bus.IMEM_addr_i is registered into a synchronous read; the word appears on
//   bus.IMEM_data_o one cycle later. Misaligned, out-of-range, or held fetches
//   return NOP_INSTR instead of memory contents.
//   A byte-serial loader (valid/ready) fills memory little-endian from word 0
//   and keeps core_hold_o high until the image is complete.
// Ports
//   clk_i     : clock, rising edge
//   resetn_i  : asynchronous active-low reset (memory contents are kept)
//   bus       : toast_imem_responder_if.slave (fetch bus + loader handshake)
// ---------------------------------------------------------------------------
module toast_imem_responder #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  toast_imem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Size of the memory in bytes, one bit wider than the address so the
  // comparison cannot overflow.
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  // One bit wider than the word index: the MSB set means the memory is full.
  logic [IDX_W:0]        wr_ptr_reg, wr_ptr_next;
  logic [1:0]            byte_cnt_reg, byte_cnt_next;
  // Lanes 0..2 of the word being assembled; lane 3 comes straight from the
  // input byte when the word completes.
  logic [23:0]           lane_buf_reg, lane_buf_next;
  logic                  ovf_reg, ovf_next;
  logic                  ready_reg, done_reg, hold_reg;

  logic                  accept;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rd_word_reg;
  logic                  nop_sel_reg;
  logic                  err_reg;

  logic [IDX_W-1:0]      rd_idx;
  logic                  misaligned;
  logic                  out_of_range;

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  assign rd_idx       = bus.IMEM_addr_i[2 +: IDX_W];
  assign misaligned   = |bus.IMEM_addr_i[1:0];
  assign out_of_range = {1'b0, bus.IMEM_addr_i} >= MEM_BYTES;

  // Plain registered read so the array maps onto block RAM. Same-edge writes
  // land after this read samples, so read-during-write returns old data.
  always_ff @(posedge clk_i) begin
    rd_word_reg <= mem[rd_idx];
  end

  // The NOP substitution is decided alongside the read and muxed after the
  // RAM register; the select resets to 1 so the core sees NOP out of reset.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      nop_sel_reg <= 1'b1;
      err_reg     <= 1'b0;
    end else begin
      nop_sel_reg <= misaligned | out_of_range | hold_reg;
      err_reg     <= misaligned;
    end
  end

  assign bus.IMEM_data_o = nop_sel_reg ? NOP_INSTR : rd_word_reg;
  assign bus.addr_err_o  = err_reg;

  // -------------------------------------------------------------------------
  // Write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Loader FSM
  // -------------------------------------------------------------------------
  assign accept = bus.load_valid_i & ready_reg;

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    byte_cnt_next = byte_cnt_reg;
    lane_buf_next = lane_buf_reg;
    ovf_next      = ovf_reg;
    wr_en         = 1'b0;
    wr_idx        = wr_ptr_reg[IDX_W-1:0];
    wr_data       = {8'h00, lane_buf_reg};

    case (state_reg)
      ST_RUN: begin
        if (bus.load_start_i) begin
          state_next    = ST_LOAD;
          wr_ptr_next   = '0;
          byte_cnt_next = '0;
          lane_buf_next = '0;
          ovf_next      = 1'b0;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          if (wr_ptr_reg[IDX_W]) begin
            // Memory full: swallow the byte, never wrap onto word 0.
            ovf_next = 1'b1;
          end else if (byte_cnt_reg == 2'd3) begin
            wr_en         = 1'b1;
            wr_data       = {bus.load_byte_i, lane_buf_reg};
            wr_ptr_next   = wr_ptr_reg + {{IDX_W{1'b0}}, 1'b1};
            byte_cnt_next = 2'd0;
            // Cleared so a trailing partial word flushes with zero upper lanes.
            lane_buf_next = '0;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (byte_cnt_reg == 2'(i)) begin
                lane_buf_next[8*i +: 8] = bus.load_byte_i;
              end
            end
            byte_cnt_next = byte_cnt_reg + 2'd1;
          end
          if (bus.load_last_i) begin
            state_next = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        // byte_cnt stays 0 once full, so the full check is only a safeguard.
        if (byte_cnt_reg != 2'd0 && !wr_ptr_reg[IDX_W]) begin
          wr_en = 1'b1;
        end
        state_next = ST_DONE;
      end

      ST_DONE: begin
        state_next = ST_RUN;
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register itself.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg    <= ST_RUN;
      wr_ptr_reg   <= '0;
      byte_cnt_reg <= '0;
      lane_buf_reg <= '0;
      ovf_reg      <= 1'b0;
      ready_reg    <= 1'b0;
      done_reg     <= 1'b0;
      hold_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      byte_cnt_reg <= byte_cnt_next;
      lane_buf_reg <= lane_buf_next;
      ovf_reg      <= ovf_next;
      ready_reg    <= (state_next == ST_LOAD);
      done_reg     <= (state_next == ST_DONE);
      hold_reg     <= (state_next != ST_RUN);
    end
  end

  assign bus.load_ready_o = ready_reg;
  assign bus.load_done_o  = done_reg;
  assign bus.load_ovf_o   = ovf_reg;
  assign bus.core_hold_o  = hold_reg;

endmodule
